// File: rtl/stitch_pkg.sv
// rtl/stitch_pkg.sv - shared types for the stream-control token generator
package stitch_pkg;

    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } streamctl_state_e;

    typedef struct packed {
        logic [CNT_WIDTH-1:0] count;
    } streamctl_cfg_t;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - synchronous FIFO with typed payload, sync active-low reset and flush
module fifo_v3 #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    dtype          r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] ptr_incr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_incr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_incr(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/stitch_streamctl_gen.sv
// rtl/stitch_streamctl_gen.sv - continue/done token generator for the FPU sequencer stream-control port
// Optional SSR credit gating of continue tokens: STITCH_STREAMCTL_CREDIT_EN.
module stitch_streamctl_gen
    import stitch_pkg::*;
#(
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned CfgDepth    = 4,
    parameter int unsigned CreditWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CntWidth-1:0] cfg_count_i,
    input  logic                abort_i,
    input  logic                ssr_credit_i,
    output logic                streamctl_valid_o,
    output logic                streamctl_done_o,
    input  logic                streamctl_ready_i,
    output logic                busy_o
);
    streamctl_state_e    r_state, w_state_d;
    logic [CntWidth-1:0] r_remaining, w_remaining_d;
    logic                r_abort_pend, w_abort_pend_d;
    logic                r_stall, w_stall_d;

    logic           w_credit_ok;
    logic           w_cont_valid;
    logic           w_cont_hs;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    streamctl_cfg_t w_push_cfg;
    streamctl_cfg_t w_pop_cfg;

    assign w_push_cfg.count = CNT_WIDTH'(cfg_count_i);
    assign w_push           = cfg_valid_i & ~w_full;
    assign cfg_ready_o      = ~w_full;

    fifo_v3 #(
        .DEPTH (CfgDepth),
        .dtype (streamctl_cfg_t)
    ) u_cfg_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .push_i  (w_push),
        .data_i  (w_push_cfg),
        .pop_i   (w_pop),
        .data_o  (w_pop_cfg),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // A stalled continue token keeps presenting even after an abort is latched.
    assign w_cont_valid      = (r_state == STREAM) & w_credit_ok & (~r_abort_pend | r_stall);
    assign w_cont_hs         = w_cont_valid & streamctl_ready_i;
    assign streamctl_valid_o = w_cont_valid | (r_state == DONE);
    assign streamctl_done_o  = (r_state == DONE);
    assign busy_o            = (r_state != IDLE) | ~w_empty;

`ifdef STITCH_STREAMCTL_CREDIT_EN
    logic [CreditWidth-1:0] r_credit;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_credit <= '0;
        end else if (ssr_credit_i && !w_cont_hs) begin
            if (r_credit != '1) r_credit <= r_credit + CreditWidth'(1);
        end else if (!ssr_credit_i && w_cont_hs) begin
            r_credit <= r_credit - CreditWidth'(1);
        end
    end

    assign w_credit_ok = (r_credit != '0);
`else
    logic w_unused;
    assign w_unused    = ssr_credit_i ^ (CreditWidth > 32'd0);
    assign w_credit_ok = 1'b1;
`endif

    always_comb begin
        w_state_d      = r_state;
        w_remaining_d  = r_remaining;
        w_abort_pend_d = r_abort_pend;
        w_stall_d      = w_cont_valid & ~streamctl_ready_i;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_remaining_d = CntWidth'(w_pop_cfg.count);
                    w_state_d     = (w_pop_cfg.count != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (abort_i) w_abort_pend_d = 1'b1;
                if (w_cont_hs) begin
                    w_remaining_d = r_remaining - CntWidth'(1);
                    if (r_remaining == CntWidth'(1) || r_abort_pend) w_state_d = DONE;
                end else if (!w_cont_valid && r_abort_pend) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                if (streamctl_ready_i) begin
                    w_abort_pend_d = 1'b0;
                    if (!w_empty) begin
                        w_pop         = 1'b1;
                        w_remaining_d = CntWidth'(w_pop_cfg.count);
                        w_state_d     = (w_pop_cfg.count != '0) ? STREAM : DONE;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_remaining  <= '0;
            r_abort_pend <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_remaining  <= w_remaining_d;
            r_abort_pend <= w_abort_pend_d;
            r_stall      <= w_stall_d;
        end
    end

endmodule

// File: doc/stitch_streamctl_gen.md
# stitch_streamctl_gen

Stream-control token generator that drives the SSR stream-control handshake consumed by the FPU sequencer. It accepts loop configurations from the SSR/core side and queues them. For each configuration it emits N "continue" tokens, each consumed once per issued sequenced instruction, followed by exactly one "done" token that terminates the outer stream-controlled FREP loop. It sits between the SSR stream bookkeeping and the sequencer's `streamctl_*` inputs.

## Interface
- `CntWidth`, 16: width of the token count; matches sequencer repeat-counter width.
- `CfgDepth`, 4: depth of the pending-configuration queue (≥1).
- `CreditWidth`, 8: width of the SSR data-credit counter (used only with credits enabled).

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `cfg_valid_i` in 1: new loop configuration valid.
- `cfg_ready_o` out 1: configuration queue not full.
- `cfg_count_i` in CntWidth: number N of continue tokens before done.
- `abort_i` in 1: pulse; terminate the current loop early.
- `ssr_credit_i` in 1: pulse; one stream beat became available.
- `streamctl_valid_o` out 1: token valid.
- `streamctl_done_o` out 1: token is done (1) or continue (0).
- `streamctl_ready_i` in 1: sequencer accepts token.
- `busy_o` out 1: state ≠ IDLE or queue non-empty.

## Operation
- States: IDLE, STREAM, DONE. `remaining_q` (CntWidth), `abort_pend_q`, `credit_q` (CreditWidth).
- IDLE: if queue non-empty, pop. Load `remaining_q = N`. Go to STREAM if N≠0, else DONE.
- STREAM: present a continue token when `credit_ok & ~abort_pend_q`. On handshake, decrement `remaining_q`. If it was 1, go to DONE.
- STREAM with `abort_pend_q` and no continue token presented: go to DONE.
- DONE: present `valid=1, done=1`. On handshake, clear `abort_pend_q`. If queue non-empty, pop and load the next config directly (no IDLE cycle). Otherwise go to IDLE.
- Stability: once `streamctl_valid_o` is high, `valid` and `done` hold until handshake.
- Abort:
  - Latched into `abort_pend_q` in STREAM only; ignored in IDLE and DONE.
  - If a continue token is presented and stalled, it completes first. Done follows on the next cycle.
- Credit:
  - `credit_q` increments on `ssr_credit_i` and decrements on a continue handshake. Simultaneous events leave it unchanged.
  - Saturates at max; never underflows.
  - `credit_ok = credit_q != 0`.
  - Done tokens need no credit.
- Configurations pushed on `cfg_valid_i & cfg_ready_o`. Queue is FIFO order.

## Timing
- Reset:
  - state=IDLE; `remaining_q`, `abort_pend_q`, `credit_q` = 0; queue flushed.
  - `streamctl_valid_o=0`, `streamctl_done_o=0`, `busy_o=0`, `cfg_ready_o=1`.
- Reset mid-loop: outputs take reset values on the cycle after `rst_ni` is sampled low. The partial loop is discarded.
- Config accepted at cycle t into an empty queue while IDLE: popped at t+1, first token valid at t+2.
- Back-to-back: DONE handshake at t, next config's first token at t+1.
- All outputs are functions of registers only; no combinational input→output path.
- `credit_q`/`abort_pend_q` updates are visible on the cycle after the pulse.
- Throughput: one token per cycle with `streamctl_ready_i` held high.

## Configuration
- `STITCH_STREAMCTL_CREDIT_EN` defined:
  - Credit counter is instantiated.
  - Continue tokens are gated by `credit_ok`.
- `STITCH_STREAMCTL_CREDIT_EN` undefined:
  - Counter is removed and `credit_ok` is tied to 1.
  - `ssr_credit_i` is ignored; `CreditWidth` is unused.

## Structure
- `stitch_pkg`:
  - `streamctl_state_e` (IDLE/STREAM/DONE).
  - `streamctl_cfg_t` (packed: `count`).
- Sub-module: `fifo_v3` for the configuration queue.
  - `dtype=streamctl_cfg_t`, `DEPTH=CfgDepth`.
  - `flush_i=0`, `rst_ni` wired directly.

## Test plan
- N=3, ready=1, credits plentiful → valid for 4 consecutive cycles, done=0,0,0,1; `busy_o` falls the following cycle.
- N=0 → exactly one handshake, done=1; `remaining_q` never decrements.
- N=3, ready low 2 cycles after first handshake → valid=1 and done=0 held stable; totals remain 3 continue + 1 done.
- N=5, abort pulsed after first handshake while second token stalled → second continue completes, then done; 2 continues + done total.
- Credit macro on, N=2, `credit_q`=0 → valid=0. One credit pulse → one continue. Second pulse → continue then done. Credit and consume in the same cycle leave `credit_q` unchanged.
- Two configs N=1,N=1 queued → 4 consecutive handshakes, no bubble. Fill queue → `cfg_ready_o=0`. Reset asserted mid-stream → all outputs 0 next cycle and queue empty.
